// File: rtl/passcode_checker_pkg.sv
// Shared state encoding and keypad command codes for the passcode checker.
// StProgram only exists when PASSCODE_CHANGE_EN is defined.
package passcode_checker_pkg;

  typedef enum logic [2:0] {
    StEntry,
    StCheck,
    StFail,
    StOpen,
    StLockout
`ifdef PASSCODE_CHANGE_EN
    , StProgram
`endif
  } state_e;

  localparam logic [3:0] KEY_ENTER     = 4'hA;
  localparam logic [3:0] KEY_CLEAR     = 4'hB;
  localparam logic [3:0] KEY_CHANGE    = 4'hC;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

  function automatic logic is_digit(logic [3:0] k);
    return k <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad debouncer: one key_evt per press once flag and code are stable for
// DEBOUNCE_CYCLES cycles; re-arms only after flag is low for as long.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_flag,
  output logic       key_evt,
  output logic [3:0] key_val
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic            armed_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      val_q;

  // Armed: count stable-high cycles, restarting on a fresh press or code change.
  always_comb begin
    if (armed_q && (cnt_q == '0 || key_code != val_q)) begin
      cnt_d = CntW'(1);
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
      cnt_q   <= '0;
      val_q   <= '0;
      key_evt <= 1'b0;
      key_val <= '0;
    end else begin
      key_evt <= 1'b0;
      // Armed counts highs, disarmed counts lows; the other level restarts.
      if (armed_q == key_flag) begin
        val_q <= key_code;
        if (cnt_d == CntMax) begin
          cnt_q   <= '0;
          armed_q <= ~armed_q;
          if (armed_q) begin
            key_evt <= 1'b1;
            key_val <= key_code;
          end
        end else begin
          cnt_q <= cnt_d;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/passcode_checker.sv
// Keypad passcode lock with retry lockout and timed unlock.
// Define PASSCODE_CHANGE_EN to allow reprogramming the code while unlocked.
module passcode_checker
  import passcode_checker_pkg::*;
#(
  parameter int unsigned CODE_LEN = 4,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE = 16'h1234,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned OPEN_CYCLES = 500000000,
  parameter int unsigned LOCKOUT_CYCLES = 1000000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_flag,
  output logic       unlocked,
  output logic       fail_pulse,
  output logic       locked_out,
  output logic [2:0] digit_count
);

  localparam int unsigned CodeW  = 4 * CODE_LEN;
  localparam int unsigned TmrMax = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);

  localparam logic [TmrW-1:0]   OpenLast   = TmrW'(OPEN_CYCLES - 1);
  localparam logic [TmrW-1:0]   LockLast   = TmrW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]        DigitsFull = 3'(CODE_LEN);
  localparam logic [TriesW-1:0] TriesMax   = TriesW'(MAX_TRIES);

  state_e            state_q;
  logic [CodeW-1:0]  buf_q, buf_shift, stored_code;
  logic [TriesW-1:0] tries_q, tries_inc;
  logic [TmrW-1:0]   tmr_q;
  logic              key_evt, take_digit, code_match;
  logic [3:0]        key_val;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_code(key_code),
    .key_flag(key_flag),
    .key_evt (key_evt),
    .key_val (key_val)
  );

`ifndef PASSCODE_CHANGE_EN
  assign stored_code = DEFAULT_CODE;
`endif

  always_comb begin
    buf_shift  = CodeW'({buf_q, key_val});
    tries_inc  = tries_q + TriesW'(1);
    code_match = (digit_count == DigitsFull) && (buf_q == stored_code);
    take_digit = key_evt && is_digit(key_val) && (digit_count != DigitsFull);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEntry;
      buf_q       <= '0;
      digit_count <= '0;
      tries_q     <= '0;
      tmr_q       <= '0;
      unlocked    <= 1'b0;
      fail_pulse  <= 1'b0;
      locked_out  <= 1'b0;
`ifdef PASSCODE_CHANGE_EN
      stored_code <= DEFAULT_CODE;
`endif
    end else begin
      fail_pulse <= 1'b0;
      unique case (state_q)
        StEntry: begin
          if (take_digit) begin
            buf_q       <= buf_shift;
            digit_count <= digit_count + 3'd1;
          end else if (key_evt && key_val == KEY_ENTER) begin
            state_q <= StCheck;
          end else if (key_evt && key_val == KEY_CLEAR) begin
            buf_q       <= '0;
            digit_count <= '0;
          end
        end
        StCheck: begin
          if (code_match) begin
            state_q  <= StOpen;
            tries_q  <= '0;
            tmr_q    <= '0;
            unlocked <= 1'b1;
          end else begin
            buf_q       <= '0;
            digit_count <= '0;
            fail_pulse  <= 1'b1;
            tries_q     <= tries_inc;
            tmr_q       <= '0;
            if (tries_inc >= TriesMax) begin
              state_q    <= StLockout;
              locked_out <= 1'b1;
            end else begin
              state_q <= StFail;
            end
          end
        end
        StFail: state_q <= StEntry;
        StOpen: begin
          if (tmr_q == OpenLast || (key_evt && key_val == KEY_CLEAR)) begin
            state_q     <= StEntry;
            unlocked    <= 1'b0;
            buf_q       <= '0;
            digit_count <= '0;
`ifdef PASSCODE_CHANGE_EN
          end else if (key_evt && key_val == KEY_CHANGE) begin
            // Timer holds its value; PROGRAM never returns to OPEN.
            state_q     <= StProgram;
            buf_q       <= '0;
            digit_count <= '0;
`endif
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
        StLockout: begin
          if (tmr_q == LockLast) begin
            state_q    <= StEntry;
            tries_q    <= '0;
            locked_out <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TmrW'(1);
          end
        end
`ifdef PASSCODE_CHANGE_EN
        StProgram: begin
          if (take_digit) begin
            buf_q       <= buf_shift;
            digit_count <= digit_count + 3'd1;
          end else if (key_evt && (key_val == KEY_ENTER || key_val == KEY_CLEAR)) begin
            if (key_val == KEY_ENTER && digit_count == DigitsFull) begin
              stored_code <= buf_q;
            end
            state_q     <= StEntry;
            unlocked    <= 1'b0;
            buf_q       <= '0;
            digit_count <= '0;
          end
        end
`endif
        default: state_q <= StEntry;
      endcase
    end
  end

endmodule
